// File: rtl/input_debounce_pkg.sv
// -----------------------------------------------------------------------------
// input_debounce_pkg
// Shared definitions for the button/switch debouncer:
//   - channel FSM state encoding
//   - default synchroniser depth and stability window
//   - counter width helper
// -----------------------------------------------------------------------------
package input_debounce_pkg;

    localparam logic ST_STABLE  = 1'b0;
    localparam logic ST_PENDING = 1'b1;

    localparam int DEBOUNCE_SYNC_STAGES   = 2;
    localparam int DEBOUNCE_STABLE_CYCLES = 50000;

    typedef enum logic {
        STABLE  = ST_STABLE,
        PENDING = ST_PENDING
    } chan_state_e;

    // Width that holds 0..cycles without wrapping; at least one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/input_debounce_chan.sv
// -----------------------------------------------------------------------------
// debounce_chan
// One debounce channel: SYNC_STAGES-deep synchroniser, STABLE/PENDING FSM and
// a stability counter. A new level is accepted only after it has been seen
// continuously for the full window; returning to the old level restarts it.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   raw    asynchronous pad level
//   clean  debounced level (registered)
//   rise   one-cycle pulse on clean 0->1 (registered)
//   fall   one-cycle pulse on clean 1->0 (registered)
// SYNC_STAGES must be >= 2, STABLE_CYCLES must be >= 1.
// -----------------------------------------------------------------------------
module debounce_chan
    import input_debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = DEBOUNCE_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEBOUNCE_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall
);

    localparam int             CW       = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    chan_state_e            state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   clean_q, clean_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            state_q <= STABLE;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            STABLE: begin
                if (s != clean_q) begin
                    state_d = PENDING;
                    cnt_d   = '0;
                end
            end
            PENDING: begin
                if (s == clean_q) begin
                    // bounced back to the old level: abandon this window
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    clean_d = s;
                    rise_d  = s;
                    fall_d  = ~s;
                    state_d = STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign clean = clean_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/input_debounce.sv
// -----------------------------------------------------------------------------
// input_debounce
// N independent debounce channels feeding the GPIO peripheral's btn/sw inputs
// (bits [1:0] buttons, [3:2] switches in the default build).
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   raw_in     asynchronous pad levels
//   clean_out  debounced levels
//   rise/fall  one-cycle per-channel edge pulses (registered)
//   changed    OR of all rise|fall bits in the same cycle
// Optional (macro INPUT_DEBOUNCE_IRQ_EN):
//   evt_pending  sticky per-channel event latch
//   irq          registered, high while any evt_pending bit is set
//   irq_ack      one-cycle pulse clearing evt_pending; a simultaneous new
//                event keeps its bit set
// -----------------------------------------------------------------------------
module input_debounce
    import input_debounce_pkg::*;
#(
    parameter int N             = 4,
    parameter int SYNC_STAGES   = DEBOUNCE_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEBOUNCE_STABLE_CYCLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] raw_in,
    output logic [N-1:0] clean_out,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic         changed
`ifdef INPUT_DEBOUNCE_IRQ_EN
    ,
    output logic [N-1:0] evt_pending,
    output logic         irq,
    input  logic         irq_ack
`endif
);

    for (genvar g = 0; g < N; g++) begin : g_chan
        debounce_chan #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_chan (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (raw_in[g]),
            .clean(clean_out[g]),
            .rise (rise[g]),
            .fall (fall[g])
        );
    end

    // rise/fall are registered, so this OR has no path from raw_in
    assign changed = |(rise | fall);

`ifdef INPUT_DEBOUNCE_IRQ_EN
    logic [N-1:0] evt_pending_q, evt_pending_d;
    logic         irq_q;

    // set term applied after the clear so a same-cycle event survives the ack
    always_comb begin
        evt_pending_d = evt_pending_q;
        if (irq_ack) evt_pending_d = '0;
        evt_pending_d = evt_pending_d | rise | fall;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_pending_q <= '0;
            irq_q         <= 1'b0;
        end else begin
            evt_pending_q <= evt_pending_d;
            irq_q         <= |evt_pending_d;
        end
    end

    assign evt_pending = evt_pending_q;
    assign irq         = irq_q;
`endif

endmodule
